alarm_time_setter: RTL and testbench

//  Button-driven editor that produces the alarm-time digits (hr1,hr0,min1,min0) consumed by alarm_clock.
//  Two buttons: MODE steps through the digits, INC increments the selected digit.

---
 rtl/alarm_time_setter.sv | 207 ++++++++++++++++++++
 tb/tb_alarm_time_setter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_time_setter.sv
// Alarm-time editor: MODE walks hr1 -> hr0 -> min1 -> min0, INC bumps the
// selected digit. Edits live in shadow registers and are committed in one
// cycle on leaving SET_MIN0, so the alarm outputs never show a partial time.
module alarm_time_setter #(
  parameter int unsigned REPEAT_DLY = 50,
  parameter int unsigned REPEAT_PER = 10,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned BLINK_DIV  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hr1,
  output logic [3:0] hr0,
  output logic [2:0] min1,
  output logic [3:0] min0,
  output logic       set_active,
  output logic [1:0] cur_digit,
  output logic       blink
);

  localparam int unsigned RPT_W = $clog2(REPEAT_DLY + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV + 1);

  typedef enum logic [2:0] {
    IDLE,
    SET_HR1,
    SET_HR0,
    SET_MIN1,
    SET_MIN0
  } state_t;

  state_t state;

  logic             prev_mode;
  logic             prev_inc;
  logic [RPT_W-1:0] rpt_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [BLK_W-1:0] blk_cnt;

  logic [1:0] sh_hr1;
  logic [3:0] sh_hr0;
  logic [2:0] sh_min1;
  logic [3:0] sh_min0;

  logic       editing;
  logic       mode_rise;
  logic       inc_rise;
  logic       rpt_fire;
  logic       inc_ev;
  logic       timeout_hit;
  logic       going_idle;
  logic [1:0] hr1_inc;
  logic [3:0] hr0_inc;
  logic [2:0] min1_inc;
  logic [3:0] min0_inc;

  // Edge detection, event qualification and per-digit wrap-around increments
  always_comb begin
    editing   = (state != IDLE);
    mode_rise = btn_mode & ~prev_mode;
    inc_rise  = btn_inc & ~prev_inc;
    rpt_fire  = editing & btn_inc & (rpt_cnt == RPT_W'(REPEAT_DLY - 1));
    // MODE has priority over INC when both rise together
    inc_ev    = editing & ~mode_rise & (inc_rise | rpt_fire);
    // Only a cycle with no button event counts as idle time
    timeout_hit = editing & ~mode_rise & ~inc_ev & (to_cnt == TO_W'(TIMEOUT - 1));
    going_idle  = timeout_hit | ((state == SET_MIN0) & mode_rise);

    hr1_inc  = (sh_hr1 >= 2'd2) ? 2'd0 : sh_hr1 + 2'd1;
    if (sh_hr1 == 2'd2) begin
      hr0_inc = (sh_hr0 >= 4'd3) ? 4'd0 : sh_hr0 + 4'd1;
    end else begin
      hr0_inc = (sh_hr0 >= 4'd9) ? 4'd0 : sh_hr0 + 4'd1;
    end
    min1_inc = (sh_min1 >= 3'd5) ? 3'd0 : sh_min1 + 3'd1;
    min0_inc = (sh_min0 >= 4'd9) ? 4'd0 : sh_min0 + 4'd1;
  end

  // Previous button levels; reset to 1 so a button held through reset gives no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_mode <= 1'b1;
      prev_inc  <= 1'b1;
    end else begin
      prev_mode <= btn_mode;
      prev_inc  <= btn_inc;
    end
  end

  // Auto-repeat counter: first fire after REPEAT_DLY held cycles, then every REPEAT_PER
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else if (!editing || !btn_inc || mode_rise || timeout_hit) begin
      rpt_cnt <= '0;
    end else if (rpt_fire) begin
      rpt_cnt <= RPT_W'(REPEAT_DLY - REPEAT_PER);
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  // Idle-time counter for aborting an abandoned edit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!editing || mode_rise || inc_ev || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Blink divider, active only while editing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (!editing || going_idle) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt <= '0;
      blink   <= ~blink;
    end else begin
      blk_cnt <= blk_cnt + BLK_W'(1);
    end
  end

  // Edit FSM with shadow digits and the committed alarm outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      set_active <= 1'b0;
      cur_digit  <= 2'd0;
      hr1        <= 2'd0;
      hr0        <= 4'd0;
      min1       <= 3'd0;
      min0       <= 4'd0;
      sh_hr1     <= 2'd0;
      sh_hr0     <= 4'd0;
      sh_min1    <= 3'd0;
      sh_min0    <= 4'd0;
    end else if (state == IDLE) begin
      if (mode_rise) begin
        state      <= SET_HR1;
        set_active <= 1'b1;
        cur_digit  <= 2'd3;
        sh_hr1     <= hr1;
        sh_hr0     <= hr0;
        sh_min1    <= min1;
        sh_min0    <= min0;
      end
    end else if (timeout_hit) begin
      state      <= IDLE;
      set_active <= 1'b0;
      cur_digit  <= 2'd0;
    end else if (mode_rise) begin
      case (state)
        SET_HR1: begin
          state     <= SET_HR0;
          cur_digit <= 2'd2;
        end
        SET_HR0: begin
          state     <= SET_MIN1;
          cur_digit <= 2'd1;
        end
        SET_MIN1: begin
          state     <= SET_MIN0;
          cur_digit <= 2'd0;
        end
        SET_MIN0: begin
          state      <= IDLE;
          set_active <= 1'b0;
          cur_digit  <= 2'd0;
          hr1        <= sh_hr1;
          hr0        <= sh_hr0;
          min1       <= sh_min1;
          min0       <= sh_min0;
        end
        default: begin
          state      <= IDLE;
          set_active <= 1'b0;
          cur_digit  <= 2'd0;
        end
      endcase
    end else if (inc_ev) begin
      case (state)
        SET_HR1: begin
          sh_hr1 <= hr1_inc;
          // Moving into the 20s forces the units into 0..3
          if ((hr1_inc == 2'd2) && (sh_hr0 > 4'd3)) begin
            sh_hr0 <= 4'd3;
          end
        end
        SET_HR0:  sh_hr0  <= hr0_inc;
        SET_MIN1: sh_min1 <= min1_inc;
        SET_MIN0: sh_min0 <= min0_inc;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_time_setter.sv
// Bench for alarm_time_setter: table of button actions with expected
// outputs, plus hand sequences for blink, timeout, auto-repeat and reset.
module tb_alarm_time_setter;

  localparam int unsigned REPEAT_DLY = 50;
  localparam int unsigned REPEAT_PER = 10;
  localparam int unsigned TIMEOUT    = 1000;
  localparam int unsigned BLINK_DIV  = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] hr1;
  logic [3:0] hr0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic       set_active;
  logic [1:0] cur_digit;
  logic       blink;

  always #5 clk = ~clk;

  alarm_time_setter #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER),
    .TIMEOUT   (TIMEOUT),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hr1       (hr1),
    .hr0       (hr0),
    .min1      (min1),
    .min0      (min0),
    .set_active(set_active),
    .cur_digit (cur_digit),
    .blink     (blink)
  );

  typedef struct packed {
    logic [1:0] hr1;
    logic [3:0] hr0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic       sa;
    logic [1:0] cd;
  } exp_t;

  typedef enum int {OP_NONE, OP_MODE, OP_INC, OP_BOTH} op_t;

  typedef struct {
    string name;
    op_t   op;
    int    reps;
    exp_t  exp;
  } vec_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;

  function automatic exp_t mk(int h1, int h0, int m1, int m0, int sa, int cd);
    exp_t e;
    e.hr1  = 2'(h1);
    e.hr0  = 4'(h0);
    e.min1 = 3'(m1);
    e.min0 = 4'(m0);
    e.sa   = 1'(sa);
    e.cd   = 2'(cd);
    return e;
  endfunction

  function automatic void add_vec(string nm, op_t op, int reps, exp_t e);
    vec_t v;
    v.name = nm;
    v.op   = op;
    v.reps = reps;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  task automatic expect_push(input string nm, input exp_t e);
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic expect_pop();
    exp_t  e;
    exp_t  a;
    string nm;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e  = sb.pop_front();
      nm = sb_name.pop_front();
      a  = {hr1, hr0, min1, min0, set_active, cur_digit};
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %0d%0d:%0d%0d set_active=%0b cur_digit=%0d, want %0d%0d:%0d%0d set_active=%0b cur_digit=%0d",
                 nm, a.hr1, a.hr0, a.min1, a.min0, a.sa, a.cd,
                 e.hr1, e.hr0, e.min1, e.min0, e.sa, e.cd);
      end
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, want %0b", nm, act, exp);
    end
  endtask

  // One-cycle press, one release cycle, return on the negedge after that
  task automatic press(input op_t op);
    @(negedge clk);
    btn_mode = (op == OP_MODE) || (op == OP_BOTH);
    btn_inc  = (op == OP_INC)  || (op == OP_BOTH);
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      expect_push(vecs[i].name, vecs[i].exp);
      for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].op);
      expect_pop();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Entry and commit of 13:55
    add_vec("reset_idle",    OP_NONE, 1, mk(0,0,0,0,0,0));
    add_vec("enter_hr1",     OP_MODE, 1, mk(0,0,0,0,1,3));
    add_vec("hr1_inc1",      OP_INC,  1, mk(0,0,0,0,1,3));
    add_vec("to_hr0",        OP_MODE, 1, mk(0,0,0,0,1,2));
    add_vec("hr0_inc3",      OP_INC,  3, mk(0,0,0,0,1,2));
    add_vec("to_min1",       OP_MODE, 1, mk(0,0,0,0,1,1));
    add_vec("min1_inc5",     OP_INC,  5, mk(0,0,0,0,1,1));
    add_vec("to_min0",       OP_MODE, 1, mk(0,0,0,0,1,0));
    add_vec("min0_inc5",     OP_INC,  5, mk(0,0,0,0,1,0));
    add_vec("commit_1355",   OP_MODE, 1, mk(1,3,5,5,0,0));
    // 13:55 -> 19:00 with wraps on min1 and min0
    add_vec("idle_inc_ign",  OP_INC,  2, mk(1,3,5,5,0,0));
    add_vec("s_enter",       OP_MODE, 1, mk(1,3,5,5,1,3));
    add_vec("s_to_hr0",      OP_MODE, 1, mk(1,3,5,5,1,2));
    add_vec("s_hr0_to9",     OP_INC,  6, mk(1,3,5,5,1,2));
    add_vec("s_to_min1",     OP_MODE, 1, mk(1,3,5,5,1,1));
    add_vec("s_min1_wrap",   OP_INC,  1, mk(1,3,5,5,1,1));
    add_vec("s_to_min0",     OP_MODE, 1, mk(1,3,5,5,1,0));
    add_vec("s_min0_wrap",   OP_INC,  5, mk(1,3,5,5,1,0));
    add_vec("commit_1900",   OP_MODE, 1, mk(1,9,0,0,0,0));
    // Clamp 29 -> 23, then hr0 wraps 3 -> 0 in the 20s
    add_vec("c_enter",       OP_MODE, 1, mk(1,9,0,0,1,3));
    add_vec("c_hr1_clamp",   OP_INC,  1, mk(1,9,0,0,1,3));
    add_vec("c_to_hr0",      OP_MODE, 1, mk(1,9,0,0,1,2));
    add_vec("c_hr0_wrap",    OP_INC,  1, mk(1,9,0,0,1,2));
    add_vec("c_to_min1",     OP_MODE, 1, mk(1,9,0,0,1,1));
    add_vec("c_to_min0",     OP_MODE, 1, mk(1,9,0,0,1,0));
    add_vec("commit_2000",   OP_MODE, 1, mk(2,0,0,0,0,0));
    // MODE+INC together: mode wins, hr0 untouched
    add_vec("b_enter",       OP_MODE, 1, mk(2,0,0,0,1,3));
    add_vec("b_to_hr0",      OP_MODE, 1, mk(2,0,0,0,1,2));
    add_vec("b_both",        OP_BOTH, 1, mk(2,0,0,0,1,1));
    add_vec("b_to_min0",     OP_MODE, 1, mk(2,0,0,0,1,0));
    add_vec("b_commit",      OP_MODE, 1, mk(2,0,0,0,0,0));

    rst      = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_bit("reset_blink", blink, 1'b0);

    run_rows(0, 9);

    // Blink timing and edit timeout from 13:55
    expect_push("to_enter", mk(1,3,5,5,1,3));
    press(OP_MODE);
    expect_pop();
    repeat (BLINK_DIV - 2) @(negedge clk);
    chk_bit("blink_before_toggle", blink, 1'b0);
    @(negedge clk);
    chk_bit("blink_first_toggle", blink, 1'b1);
    press(OP_INC);
    press(OP_INC);
    repeat (TIMEOUT - 2) @(negedge clk);
    expect_push("to_not_yet", mk(1,3,5,5,1,3));
    expect_pop();
    @(negedge clk);
    expect_push("to_expired", mk(1,3,5,5,0,0));
    expect_pop();
    chk_bit("to_blink_off", blink, 1'b0);

    run_rows(10, vecs.size() - 1);

    // Async reset clears outputs without a clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_push("async_reset_idle", mk(0,0,0,0,0,0));
    expect_pop();
    @(negedge clk);
    rst = 1'b0;

    // Auto-repeat: 1 edge + 5 repeats over 90 held cycles
    for (int k = 0; k < 4; k++) press(OP_MODE);
    expect_push("ar_in_min0", mk(0,0,0,0,1,0));
    expect_pop();
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (REPEAT_DLY + REPEAT_PER * 4) @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    expect_push("ar_no_partial", mk(0,0,0,0,1,0));
    expect_pop();
    expect_push("ar_commit_6", mk(0,0,0,6,0,0));
    press(OP_MODE);
    expect_pop();

    // Reset mid-edit with MODE held through reset release
    expect_push("mr_enter", mk(0,0,0,6,1,3));
    press(OP_MODE);
    expect_pop();
    press(OP_INC);
    @(negedge clk);
    btn_mode = 1'b1;
    rst      = 1'b1;
    #1;
    expect_push("mr_reset_now", mk(0,0,0,0,0,0));
    expect_pop();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_push("mr_held_no_edge", mk(0,0,0,0,0,0));
    expect_pop();
    btn_mode = 1'b0;
    @(negedge clk);
    expect_push("mr_fresh_press", mk(0,0,0,0,1,3));
    press(OP_MODE);
    expect_pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
